ram_pipe_be: RTL and testbench
==============================

Name: ram_pipe_be

Overview:
- Parametrised successor of the team's single-port 32-bit synchronous RAM.
- Adds width/depth parameters, byte-enable writes, a req/ready handshake and a configurable read-latency pipeline with valid and error flags.
- Adds a hardware clear sequence after reset and a selectable read-during-write mode.
- Sits between a simple bus master (FSM/CPU datapath) and on-chip storage; one request per cycle, in-order responses.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- ADDR_W, 7, address width.
- DEPTH, 100, number of implemented words; DEPTH <= 2**ADDR_W.
- READ_LATENCY, 1, cycles from accept edge to response; range 1..4.
- WRITE_MODE, 0, 0 = READ_FIRST (write response returns old word), 1 = WRITE_FIRST (returns merged new word).
- ERR_CODE, 32'h0000DEAD, value on rdata for out-of-range access; zero-extended or truncated to DATA_W.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  1  request valid
- we  input  1  1 = write, 0 = read
- addr  input  ADDR_W  word address
- wdata  input  DATA_W  write data
- be  input  DATA_W/8  byte enables; bit k covers wdata[8k+7:8k]
- ready  output  1  block can accept a request this cycle
- rvalid  output  1  one-cycle response pulse
- rdata  output  DATA_W  response data
- err  output  1  response was out-of-range; qualified by rvalid

Behaviour:
- Reset (async assert, sync release):
  - state = INIT, clear counter = 0, ready = 0, rvalid = 0, rdata = 0, err = 0.
  - All pipeline valid bits cleared; in-flight responses are dropped and never emitted.
- FSM, two states:
  - INIT: writes 0 to word clr_cnt each cycle, clr_cnt 0..DEPTH-1. After the write of DEPTH-1, next state is IDLE. ready = 0 throughout; req is ignored.
  - IDLE: ready = 1 permanently. No other transitions; only rst returns to INIT.
  - Reset asserted mid-INIT restarts the clear from word 0.
- Accept: a request is accepted on a rising edge where req && ready.
- Response timing:
  - Every accepted request (read or write) produces exactly one response: rvalid = 1 for one cycle, READ_LATENCY cycles after the accept edge.
  - Throughput is one per cycle. Responses are in order; back-to-back accepts give back-to-back rvalid.
- Read: rdata = mem[addr] as of the accept edge, err = 0.
- Write:
  - Only bytes with be[k] = 1 are updated at the accept edge; be = 0 is a legal no-op write that still responds.
  - rdata = old word if WRITE_MODE = 0, merged new word if WRITE_MODE = 1; err = 0.
- Out of range (addr >= DEPTH): memory unchanged, rdata = ERR_CODE, err = 1. The comparison uses the full ADDR_W width, no wrap.
- Read after write: a read accepted the cycle after a write to the same address returns the written data (no hazard at latency 1 or more).
- Outputs between responses: rdata holds the last response value; err is held too but is meaningful only with rvalid.
- Stages 2..READ_LATENCY are plain registers carrying {valid, data, err}.

Decomposition:
- Package ram_pkg:
  - localparams RAM_READ_FIRST = 0, RAM_WRITE_FIRST = 1, RAM_ERR_DEFAULT = 32'h0000DEAD.
  - FSM state encoding ST_INIT, ST_IDLE.
- One sub-module, ram_rd_pipe: a parametrised shift register (depth READ_LATENCY-1, width DATA_W+2) with async clear of the valid bits. Top holds the array, FSM, byte merge and range check.

Test Plan:
- Reset then wait: ready = 0 for exactly 100 cycles after rst release, then 1. A read of addr 57 returns 0, err = 0.
- Write addr 0 = 32'hAABBCCDD with be = 4'hF, then write addr 0 = 32'h11223344 with be = 4'b0101, then read addr 0 -> rdata = 32'hAA22CC44. Check both WRITE_MODE settings for the second write's response (32'hAABBCCDD vs 32'hAA22CC44).
- Read addr 100 and write addr 127 with wdata = 32'hFFFFFFFF -> both respond with rdata = 32'h0000DEAD, err = 1. A read of addr 99 still returns its prior value.
- READ_LATENCY = 3, reads of addr 1, 2, 3 on consecutive cycles (pre-written 1, 2, 3) -> rvalid high for 3 consecutive cycles starting 3 edges after the first accept; data 1, 2, 3 in order.
- Assert rst with two reads in flight and mid-INIT at clr_cnt = 40 -> no rvalid is ever emitted for the dropped reads. INIT restarts, and ready rises 100 cycles after release.
- Write addr 5 = 32'h5 then immediately read addr 5 -> read response = 32'h5.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the pipelined byte-enable RAM.
package ram_pkg;

    localparam int          RAM_READ_FIRST  = 0;
    localparam int          RAM_WRITE_FIRST = 1;
    localparam logic [31:0] RAM_ERR_DEFAULT = 32'h0000DEAD;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } ram_state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Response delay line: STAGES registers of {valid, err, data}.
// Valid shifts every cycle; data/err load only behind a valid, so the last stage holds the last response.
module ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    localparam int W = DATA_W + 2;

    logic [W-1:0] r_stage [STAGES];
    logic [W-1:0] w_src   [STAGES];

    always_comb begin
        w_src[0] = {i_valid, i_err, i_data};
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_src[i] = r_stage[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_stage[i][W-1] <= w_src[i][W-1];
                if (w_src[i][W-1]) begin
                    r_stage[i][W-2:0] <= w_src[i][W-2:0];
                end
            end
        end
    end

    assign o_valid = r_stage[STAGES-1][W-1];
    assign o_err   = r_stage[STAGES-1][W-2];
    assign o_data  = r_stage[STAGES-1][DATA_W-1:0];

endmodule

// File: rtl/ram_pipe_be.sv
// Single-port RAM with byte enables, req/ready handshake, post-reset clear
// sequence and a READ_LATENCY-deep in-order response pipeline.
module ram_pipe_be
    import ram_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          ADDR_W       = 7,
    parameter int          DEPTH        = 100,
    parameter int          READ_LATENCY = 1,
    parameter int          WRITE_MODE   = RAM_READ_FIRST,
    parameter logic [31:0] ERR_CODE     = RAM_ERR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int                BE_W     = DATA_W / 8;
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    ram_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_ready;

    logic              r_s1_valid;
    logic              r_s1_err;
    logic [DATA_W-1:0] r_s1_data;

    logic              w_accept;
    logic              w_in_range;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign ready      = r_ready;
    assign w_accept   = req && r_ready;
    // Extra MSB keeps the compare exact even when DEPTH == 2**ADDR_W.
    assign w_in_range = ({1'b0, addr} < LP_DEPTH);
    assign w_old      = w_in_range ? r_mem[addr] : '0;

    always_comb begin
        w_merged = w_old;
        for (int unsigned k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                w_merged[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        if (!w_in_range) begin
            w_resp_data = DATA_W'(ERR_CODE);
        end else if (we && (WRITE_MODE == RAM_WRITE_FIRST)) begin
            w_resp_data = w_merged;
        end else begin
            w_resp_data = w_old;
        end
    end

    // The clear sequence and bus writes share the single write port; INIT never accepts.
    assign w_mem_we    = (r_state == ST_INIT) || (w_accept && we && w_in_range);
    assign w_mem_addr  = (r_state == ST_INIT) ? r_clr_cnt : addr;
    assign w_mem_wdata = (r_state == ST_INIT) ? '0 : w_merged;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_clr_cnt == LP_LAST) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: r_ready <= 1'b1;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_err  <= !w_in_range;
                r_s1_data <= w_resp_data;
            end
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_pipe
            ram_rd_pipe #(
                .DATA_W (DATA_W),
                .STAGES (READ_LATENCY - 1)
            ) u_rd_pipe (
                .clk     (clk),
                .rst     (rst),
                .i_valid (r_s1_valid),
                .i_err   (r_s1_err),
                .i_data  (r_s1_data),
                .o_valid (rvalid),
                .o_err   (err),
                .o_data  (rdata)
            );
        end else begin : g_direct
            assign rvalid = r_s1_valid;
            assign err    = r_s1_err;
            assign rdata  = r_s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_pipe_be.sv
// Scoreboard bench: two DUT configurations share one stimulus stream and one array model.
module tb_ram_pipe_be;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int DEP   = 100;

    typedef struct {
        logic [31:0] data;
        logic        err;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    logic        ready_a, rvalid_a, err_a;
    logic [31:0] rdata_a;
    logic        ready_b, rvalid_b, err_b;
    logic [31:0] rdata_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    longint      cyc     = 0;
    logic [31:0] model [128];
    exp_t        q_a [$];
    exp_t        q_b [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_pipe_be #(
        .DATA_W(32), .ADDR_W(7), .DEPTH(DEP), .READ_LATENCY(LAT_A),
        .WRITE_MODE(0), .ERR_CODE(32'h0000DEAD)
    ) u_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a)
    );

    ram_pipe_be #(
        .DATA_W(32), .ADDR_W(7), .DEPTH(DEP), .READ_LATENCY(LAT_B),
        .WRITE_MODE(1), .ERR_CODE(32'h0000DEAD)
    ) u_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b)
    );

    // Monitors: a response is due at the negedge just before edge 'due'.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a) begin
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_a_unexpected: rvalid=1 data=%h at cyc %0d, required no response", rdata_a, cyc);
            end else begin
                e = q_a.pop_front();
                if (rdata_a !== e.data || err_a !== e.err || e.due != cyc + 1) begin
                    n_fail++;
                    $display("FAIL rsp_a: got data=%h err=%b edge=%0d, required data=%h err=%b edge=%0d",
                             rdata_a, err_a, cyc + 1, e.data, e.err, e.due);
                end
            end
        end else if (q_a.size() != 0 && q_a[0].due <= cyc + 1) begin
            n_tests++;
            n_fail++;
            e = q_a.pop_front();
            $display("FAIL rsp_a_missing: got rvalid=0 at edge %0d, required data=%h err=%b", cyc + 1, e.data, e.err);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_b) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_b_unexpected: rvalid=1 data=%h at cyc %0d, required no response", rdata_b, cyc);
            end else begin
                e = q_b.pop_front();
                if (rdata_b !== e.data || err_b !== e.err || e.due != cyc + 1) begin
                    n_fail++;
                    $display("FAIL rsp_b: got data=%h err=%b edge=%0d, required data=%h err=%b edge=%0d",
                             rdata_b, err_b, cyc + 1, e.data, e.err, e.due);
                end
            end
        end else if (q_b.size() != 0 && q_b[0].due <= cyc + 1) begin
            n_tests++;
            n_fail++;
            e = q_b.pop_front();
            $display("FAIL rsp_b_missing: got rvalid=0 at edge %0d, required data=%h err=%b", cyc + 1, e.data, e.err);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference behaviour: words zero after clear, byte-masked update, error word beyond DEPTH.
    task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
        exp_t ea, eb;
        logic [31:0] old_w, new_w;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        if (int'(a) >= DEP) begin
            ea.data = 32'h0000DEAD; ea.err = 1'b1;
            eb.data = 32'h0000DEAD; eb.err = 1'b1;
        end else begin
            old_w = model[a];
            new_w = old_w;
            for (int k = 0; k < 4; k++) begin
                if (b[k]) new_w[8*k +: 8] = d[8*k +: 8];
            end
            if (w) model[a] = new_w;
            ea.data = old_w;                eb.data = w ? new_w : old_w;
            ea.err  = 1'b0;                 eb.err  = 1'b0;
        end
        ea.due = cyc + 1 + LAT_A;
        eb.due = cyc + 1 + LAT_B;
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) model[i] = '0;
    endtask

    // Counts observed cycles with ready low after a release done at a negedge.
    task automatic measure_ready(input string nm);
        int n = 0;
        while (!(ready_a && ready_b) && n < 300) begin
            @(negedge clk);
            if (!(ready_a && ready_b)) n++;
            else n++;
            if (ready_a && ready_b) break;
        end
        check({nm, "_ready_cycles"}, n, 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_ready",  {ready_a, ready_b},   2'b00);
        check("reset_rvalid", {rvalid_a, rvalid_b}, 2'b00);
        check("reset_err",    {err_a, err_b},       2'b00);
        check("reset_rdata_a", rdata_a, 32'h0);
        check("reset_rdata_b", rdata_b, 32'h0);
        rst = 1'b0;
        measure_ready("init1");

        issue(1'b0, 7'd57, 32'h0, 4'h0);
        issue(1'b1, 7'd0, 32'hAABBCCDD, 4'hF);
        issue(1'b1, 7'd0, 32'h11223344, 4'b0101);
        issue(1'b0, 7'd0, 32'h0, 4'h0);
        issue(1'b1, 7'd99, 32'h12345678, 4'hF);
        issue(1'b0, 7'd100, 32'h0, 4'h0);
        issue(1'b1, 7'd127, 32'hFFFFFFFF, 4'hF);
        issue(1'b0, 7'd99, 32'h0, 4'h0);
        issue(1'b1, 7'd1, 32'h1, 4'hF);
        issue(1'b1, 7'd2, 32'h2, 4'hF);
        issue(1'b1, 7'd3, 32'h3, 4'hF);
        idle();
        issue(1'b0, 7'd1, 32'h0, 4'h0);
        issue(1'b0, 7'd2, 32'h0, 4'h0);
        issue(1'b0, 7'd3, 32'h0, 4'h0);
        idle();
        issue(1'b1, 7'd5, 32'h5, 4'hF);
        issue(1'b0, 7'd5, 32'h0, 4'h0);
        issue(1'b1, 7'd6, 32'hCAFEF00D, 4'h0);
        issue(1'b0, 7'd6, 32'h0, 4'h0);
        idle();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)));
        end
        idle();
        repeat (6) @(negedge clk);

        issue(1'b0, 7'd1, 32'h0, 4'h0);
        issue(1'b0, 7'd2, 32'h0, 4'h0);
        idle();
        #1;
        rst = 1'b1;
        q_b.delete();
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        measure_ready("init2");

        for (int i = 0; i < 30; i++) begin
            issue(1'b0, 7'($urandom_range(0, 127)), 32'h0, 4'h0);
        end
        idle();
        repeat (8) @(negedge clk);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
